// File: rtl/adma_atx_scheduler.sv
// ADMA transaction scheduler: round-robin grant of channel requests into one held AXI read/write command.
// Optional macro ADMA_SCHED_OSTD_LIMIT_EN: channels at CHN_OSTD_MAX outstanding become ineligible for grant.
module adma_atx_scheduler #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int SRC_ADDR_W    = 32,
    parameter int DST_ADDR_W    = 32,
    parameter int MST_ID_W      = 5,
    parameter int ATX_LEN_W     = 8,
    parameter int CHN_OSTD_MAX  = 4,
    parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     chn_req_vld [0:DMA_CHN_NUM-1],
    output logic                     chn_req_rdy [0:DMA_CHN_NUM-1],
    input  logic [SRC_ADDR_W-1:0]    chn_araddr  [0:DMA_CHN_NUM-1],
    input  logic [DST_ADDR_W-1:0]    chn_awaddr  [0:DMA_CHN_NUM-1],
    input  logic [ATX_LEN_W-1:0]     chn_len     [0:DMA_CHN_NUM-1],
    input  logic [1:0]               chn_burst   [0:DMA_CHN_NUM-1],
    input  logic [MST_ID_W-1:0]      atx_id      [0:DMA_CHN_NUM-1],
    input  logic                     atx_done    [0:DMA_CHN_NUM-1],
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [SRC_ADDR_W-1:0]    atx_araddr,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic [1:0]               atx_arburst,
    output logic [MST_ID_W-1:0]      atx_awid,
    output logic [DST_ADDR_W-1:0]    atx_awaddr,
    output logic [ATX_LEN_W-1:0]     atx_awlen,
    output logic [1:0]               atx_awburst,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    output logic                     chn_busy    [0:DMA_CHN_NUM-1]
);

    localparam int CNT_W = $clog2(CHN_OSTD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHN_OSTD_MAX);
    localparam logic [DMA_CHN_NUM_W-1:0] LAST_CHN = DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [DMA_CHN_NUM_W-1:0] last_grant_q, last_grant_d;
    logic [DMA_CHN_NUM_W-1:0] chn_id_q, chn_id_d;
    logic [MST_ID_W-1:0]      id_q, id_d;
    logic [SRC_ADDR_W-1:0]    araddr_q, araddr_d;
    logic [DST_ADDR_W-1:0]    awaddr_q, awaddr_d;
    logic [ATX_LEN_W-1:0]     len_q, len_d;
    logic [1:0]               burst_q, burst_d;
    logic [CNT_W-1:0]         ostd_cnt_q [0:DMA_CHN_NUM-1];
    logic [CNT_W-1:0]         ostd_cnt_d [0:DMA_CHN_NUM-1];

    logic                     eligible   [0:DMA_CHN_NUM-1];
    logic                     grant_found;
    logic [DMA_CHN_NUM_W-1:0] grant_idx;
    logic                     issue;

    always_comb begin
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
`ifdef ADMA_SCHED_OSTD_LIMIT_EN
            eligible[i] = chn_req_vld[i] && (ostd_cnt_q[i] < CNT_MAX);
`else
            eligible[i] = chn_req_vld[i];
`endif
        end
    end

    // Search starts one past the last issued channel and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= DMA_CHN_NUM; k++) begin
            cand = (32'(last_grant_q) + k) % 32'(DMA_CHN_NUM);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = DMA_CHN_NUM_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        chn_id_d     = chn_id_q;
        id_d         = id_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        len_d        = len_q;
        burst_d      = burst_q;
        issue        = 1'b0;
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
            chn_req_rdy[i] = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    chn_req_rdy[grant_idx] = 1'b1;
                    chn_id_d = grant_idx;
                    id_d     = atx_id[grant_idx];
                    araddr_d = chn_araddr[grant_idx];
                    awaddr_d = chn_awaddr[grant_idx];
                    len_d    = chn_len[grant_idx];
                    burst_d  = chn_burst[grant_idx];
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (atx_rdy) begin
                    issue        = 1'b1;
                    last_grant_d = chn_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Simultaneous issue and done cancel; the counter neither wraps at max nor underflows at zero.
    always_comb begin
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
            ostd_cnt_d[i] = ostd_cnt_q[i];
            if (issue && (chn_id_q == DMA_CHN_NUM_W'(i)) && !atx_done[i]) begin
                if (ostd_cnt_q[i] != CNT_MAX) begin
                    ostd_cnt_d[i] = ostd_cnt_q[i] + 1'b1;
                end
            end else if (atx_done[i] && !(issue && (chn_id_q == DMA_CHN_NUM_W'(i)))) begin
                if (ostd_cnt_q[i] != '0) begin
                    ostd_cnt_d[i] = ostd_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_CHN;
            chn_id_q     <= '0;
            id_q         <= '0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
                ostd_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            chn_id_q     <= chn_id_d;
            id_q         <= id_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
            for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
                ostd_cnt_q[i] <= ostd_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
            chn_busy[i] = (ostd_cnt_q[i] != '0);
        end
    end

    assign atx_vld     = (state_q == HOLD);
    assign atx_chn_id  = chn_id_q;
    assign atx_arid    = id_q;
    assign atx_awid    = id_q;
    assign atx_araddr  = araddr_q;
    assign atx_awaddr  = awaddr_q;
    assign atx_arlen   = len_q;
    assign atx_awlen   = len_q;
    assign atx_arburst = burst_q;
    assign atx_awburst = burst_q;

endmodule

// File: tb/tb_adma_atx_scheduler.sv
// Directed self-checking bench for adma_atx_scheduler (4 channels, CHN_OSTD_MAX=4).
module tb_adma_atx_scheduler;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        chn_req_vld [0:N-1];
    logic        chn_req_rdy [0:N-1];
    logic [31:0] chn_araddr  [0:N-1];
    logic [31:0] chn_awaddr  [0:N-1];
    logic [7:0]  chn_len     [0:N-1];
    logic [1:0]  chn_burst   [0:N-1];
    logic [4:0]  atx_id      [0:N-1];
    logic        atx_done    [0:N-1];
    logic [1:0]  atx_chn_id;
    logic [4:0]  atx_arid;
    logic [31:0] atx_araddr;
    logic [7:0]  atx_arlen;
    logic [1:0]  atx_arburst;
    logic [4:0]  atx_awid;
    logic [31:0] atx_awaddr;
    logic [7:0]  atx_awlen;
    logic [1:0]  atx_awburst;
    logic        atx_vld;
    logic        atx_rdy;
    logic        chn_busy    [0:N-1];

    int checks   = 0;
    int failures = 0;

    adma_atx_scheduler #(
        .DMA_CHN_NUM (4),
        .SRC_ADDR_W  (32),
        .DST_ADDR_W  (32),
        .MST_ID_W    (5),
        .ATX_LEN_W   (8),
        .CHN_OSTD_MAX(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chn_req_vld(chn_req_vld),
        .chn_req_rdy(chn_req_rdy),
        .chn_araddr (chn_araddr),
        .chn_awaddr (chn_awaddr),
        .chn_len    (chn_len),
        .chn_burst  (chn_burst),
        .atx_id     (atx_id),
        .atx_done   (atx_done),
        .atx_chn_id (atx_chn_id),
        .atx_arid   (atx_arid),
        .atx_araddr (atx_araddr),
        .atx_arlen  (atx_arlen),
        .atx_arburst(atx_arburst),
        .atx_awid   (atx_awid),
        .atx_awaddr (atx_awaddr),
        .atx_awlen  (atx_awlen),
        .atx_awburst(atx_awburst),
        .atx_vld    (atx_vld),
        .atx_rdy    (atx_rdy),
        .chn_busy   (chn_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] rdy_vec();
        logic [3:0] v;
        for (int i = 0; i < N; i++) v[i] = chn_req_rdy[i];
        return v;
    endfunction

    function automatic logic [3:0] busy_vec();
        logic [3:0] v;
        for (int i = 0; i < N; i++) v[i] = chn_busy[i];
        return v;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            chn_req_vld[i] = 1'b0;
            chn_araddr[i]  = '0;
            chn_awaddr[i]  = '0;
            chn_len[i]     = '0;
            chn_burst[i]   = '0;
            atx_id[i]      = '0;
            atx_done[i]    = 1'b0;
        end
        atx_rdy = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #7;
        checks++;
        if (atx_vld !== 1'b0 || busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_vld_busy got vld=%b busy=%b exp vld=0 busy=0000", atx_vld, busy_vec());
        end
        checks++;
        if (atx_chn_id !== 2'd0 || atx_araddr !== 32'h0 || atx_awaddr !== 32'h0 ||
            atx_arid !== 5'd0 || atx_arlen !== 8'd0 || atx_arburst !== 2'd0) begin
            failures++;
            $display("FAIL reset_fields got id=%0d ar=%h aw=%h arid=%0d len=%0d exp all 0",
                     atx_chn_id, atx_araddr, atx_awaddr, atx_arid, atx_arlen);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0000 || atx_vld !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got rdy=%b vld=%b exp rdy=0000 vld=0", rdy_vec(), atx_vld);
        end
    endtask

    task automatic test_single();
        do_reset();
        chn_req_vld[2] = 1'b1;
        chn_araddr[2]  = 32'h1000;
        chn_awaddr[2]  = 32'h8000;
        chn_len[2]     = 8'd15;
        chn_burst[2]   = 2'd1;
        atx_id[2]      = 5'd5;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0100 || atx_vld !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got rdy=%b vld=%b exp rdy=0100 vld=0", rdy_vec(), atx_vld);
        end
        advance();
        chn_req_vld[2] = 1'b0;
        chn_araddr[2]  = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd2) begin
            failures++;
            $display("FAIL single_vld got vld=%b chn=%0d exp vld=1 chn=2", atx_vld, atx_chn_id);
        end
        checks++;
        if (atx_arid !== 5'd5 || atx_awid !== 5'd5) begin
            failures++;
            $display("FAIL single_id got arid=%0d awid=%0d exp 5", atx_arid, atx_awid);
        end
        checks++;
        if (atx_arlen !== 8'd15 || atx_awlen !== 8'd15 || atx_arburst !== 2'd1 || atx_awburst !== 2'd1) begin
            failures++;
            $display("FAIL single_len got arlen=%0d awlen=%0d arb=%0d awb=%0d exp 15 15 1 1",
                     atx_arlen, atx_awlen, atx_arburst, atx_awburst);
        end
        checks++;
        if (atx_araddr !== 32'h1000 || atx_awaddr !== 32'h8000) begin
            failures++;
            $display("FAIL single_addr got ar=%h aw=%h exp 1000 8000", atx_araddr, atx_awaddr);
        end
        checks++;
        if (rdy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL single_rdy_pulse got rdy=%b exp 0000", rdy_vec());
        end
        advance();
        atx_rdy = 1'b1;
        @(negedge clk);
        advance();
        atx_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b0 || busy_vec() !== 4'b0100) begin
            failures++;
            $display("FAIL single_issue got vld=%b busy=%b exp vld=0 busy=0100", atx_vld, busy_vec());
        end
        advance();
        atx_done[2] = 1'b1;
        advance();
        atx_done[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL single_done got busy=%b exp 0000", busy_vec());
        end
    endtask

    task automatic test_round_robin();
        int         exp_order [5];
        logic [3:0] exp_rdy;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) begin
            chn_req_vld[i] = 1'b1;
            chn_araddr[i]  = 32'h100 * (i + 1);
            atx_id[i]      = 5'(i + 1);
        end
        atx_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                exp_rdy = 4'b0001 << exp_order[c / 2];
                checks++;
                if (rdy_vec() !== exp_rdy || atx_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d got rdy=%b vld=%b exp rdy=%b vld=0",
                             c, rdy_vec(), atx_vld, exp_rdy);
                end
            end else begin
                checks++;
                if (atx_vld !== 1'b1 || atx_chn_id !== 2'(exp_order[c / 2]) ||
                    atx_araddr !== 32'h100 * (exp_order[c / 2] + 1)) begin
                    failures++;
                    $display("FAIL rr_issue c=%0d got vld=%b chn=%0d ar=%h exp vld=1 chn=%0d",
                             c, atx_vld, atx_chn_id, atx_araddr, exp_order[c / 2]);
                end
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_hold_stable();
        do_reset();
        chn_req_vld[1] = 1'b1;
        chn_araddr[1]  = 32'hA0;
        chn_awaddr[1]  = 32'hB0;
        chn_len[1]     = 8'd3;
        chn_burst[1]   = 2'd2;
        atx_id[1]      = 5'd7;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL hold_grant got rdy=%b exp 0010", rdy_vec());
        end
        for (int c = 0; c < 10; c++) begin
            advance();
            chn_araddr[1]  = 32'h5000 + c;
            chn_awaddr[1]  = 32'h6000 + c;
            chn_len[1]     = 8'(c);
            chn_burst[1]   = 2'(c);
            atx_id[1]      = 5'(c + 10);
            chn_req_vld[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (atx_vld !== 1'b1 || atx_chn_id !== 2'd1 || atx_araddr !== 32'hA0 || atx_awaddr !== 32'hB0 ||
                atx_arlen !== 8'd3 || atx_awlen !== 8'd3 || atx_arburst !== 2'd2 || atx_arid !== 5'd7 ||
                atx_awid !== 5'd7) begin
                failures++;
                $display("FAIL hold_stable c=%0d got vld=%b chn=%0d ar=%h aw=%h len=%0d id=%0d exp 1 1 a0 b0 3 7",
                         c, atx_vld, atx_chn_id, atx_araddr, atx_awaddr, atx_arlen, atx_arid);
            end
            checks++;
            if (rdy_vec() !== 4'b0000) begin
                failures++;
                $display("FAIL hold_rdy c=%0d got rdy=%b exp 0000", c, rdy_vec());
            end
        end
        advance();
        atx_rdy = 1'b1;
        for (int i = 0; i < N; i++) chn_req_vld[i] = 1'b0;
        @(negedge clk);
        advance();
        atx_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b0 || busy_vec() !== 4'b0010 || rdy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL hold_release got vld=%b busy=%b rdy=%b exp 0 0010 0000", atx_vld, busy_vec(), rdy_vec());
        end
    endtask

    task automatic test_ostd_limit();
        do_reset();
        chn_req_vld[1] = 1'b1;
        chn_araddr[1]  = 32'h11;
        chn_araddr[2]  = 32'h22;
        atx_rdy        = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ((c % 2 == 0 && rdy_vec() !== 4'b0010) ||
                (c % 2 == 1 && (atx_vld !== 1'b1 || atx_chn_id !== 2'd1))) begin
                failures++;
                $display("FAIL ostd_fill c=%0d got rdy=%b vld=%b chn=%0d exp ch1", c, rdy_vec(), atx_vld, atx_chn_id);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL ostd_busy got busy=%b exp 0010", busy_vec());
        end
`ifdef ADMA_SCHED_OSTD_LIMIT_EN
        checks++;
        if (rdy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL ostd_block got rdy=%b exp 0000", rdy_vec());
        end
        for (int c = 0; c < 3; c++) begin
            advance();
            @(negedge clk);
            checks++;
            if (atx_vld !== 1'b0 || rdy_vec() !== 4'b0000) begin
                failures++;
                $display("FAIL ostd_block_hold c=%0d got vld=%b rdy=%b exp 0 0000", c, atx_vld, rdy_vec());
            end
        end
        advance();
        chn_req_vld[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0100) begin
            failures++;
            $display("FAIL ostd_other got rdy=%b exp 0100", rdy_vec());
        end
        advance();
        chn_req_vld[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd2 || atx_araddr !== 32'h22) begin
            failures++;
            $display("FAIL ostd_other_issue got vld=%b chn=%0d ar=%h exp 1 2 22", atx_vld, atx_chn_id, atx_araddr);
        end
        advance();
        atx_done[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL ostd_done_cycle got rdy=%b exp 0000", rdy_vec());
        end
        advance();
        atx_done[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL ostd_regrant got rdy=%b exp 0010", rdy_vec());
        end
        advance();
        chn_req_vld[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd1) begin
            failures++;
            $display("FAIL ostd_regrant_issue got vld=%b chn=%0d exp 1 1", atx_vld, atx_chn_id);
        end
`else
        checks++;
        if (rdy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL nolimit_grant got rdy=%b exp 0010", rdy_vec());
        end
        advance();
        chn_req_vld[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd1) begin
            failures++;
            $display("FAIL nolimit_issue got vld=%b chn=%0d exp 1 1", atx_vld, atx_chn_id);
        end
        for (int c = 0; c < 3; c++) begin
            advance();
            atx_done[1] = 1'b1;
        end
        advance();
        atx_done[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL sat_three_done got busy=%b exp 0010", busy_vec());
        end
        advance();
        atx_done[1] = 1'b1;
        advance();
        atx_done[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL sat_four_done got busy=%b exp 0000", busy_vec());
        end
`endif
        advance();
        clear_inputs();
    endtask

    task automatic test_cnt_edges();
        do_reset();
        chn_req_vld[0] = 1'b1;
        atx_rdy        = 1'b1;
        @(negedge clk);
        advance();
        @(negedge clk);
        advance();
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0001 || busy_vec() !== 4'b0001) begin
            failures++;
            $display("FAIL edge_regrant got rdy=%b busy=%b exp 0001 0001", rdy_vec(), busy_vec());
        end
        advance();
        chn_req_vld[0] = 1'b0;
        atx_done[0]    = 1'b1;
        @(negedge clk);
        advance();
        atx_done[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b0 || busy_vec() !== 4'b0001) begin
            failures++;
            $display("FAIL edge_simul got vld=%b busy=%b exp 0 0001", atx_vld, busy_vec());
        end
        advance();
        atx_done[0] = 1'b1;
        advance();
        atx_done[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL edge_simul_cnt1 got busy=%b exp 0000", busy_vec());
        end
        advance();
        atx_done[3] = 1'b1;
        advance();
        atx_done[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL edge_underflow got busy=%b exp 0000", busy_vec());
        end
        advance();
        chn_req_vld[3] = 1'b1;
        @(negedge clk);
        advance();
        chn_req_vld[3] = 1'b0;
        advance();
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b1000) begin
            failures++;
            $display("FAIL edge_ch3_issue got busy=%b exp 1000", busy_vec());
        end
        advance();
        atx_done[3] = 1'b1;
        advance();
        atx_done[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL edge_ch3_done got busy=%b exp 0000", busy_vec());
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_reset_hold();
        do_reset();
        for (int i = 0; i < N; i++) begin
            chn_araddr[i] = 32'h300 + i;
            chn_awaddr[i] = 32'h700 + i;
            chn_len[i]    = 8'd9;
            atx_id[i]     = 5'd3;
        end
        chn_req_vld[1] = 1'b1;
        atx_rdy        = 1'b1;
        advance();
        chn_req_vld[1] = 1'b0;
        advance();
        for (int i = 0; i < N; i++) chn_req_vld[i] = 1'b1;
        atx_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0100) begin
            failures++;
            $display("FAIL rsthold_grant got rdy=%b exp 0100", rdy_vec());
        end
        advance();
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd2 || busy_vec() !== 4'b0010) begin
            failures++;
            $display("FAIL rsthold_hold got vld=%b chn=%0d busy=%b exp 1 2 0010", atx_vld, atx_chn_id, busy_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (atx_vld !== 1'b0 || busy_vec() !== 4'b0000) begin
            failures++;
            $display("FAIL rsthold_async got vld=%b busy=%b exp 0 0000", atx_vld, busy_vec());
        end
        checks++;
        if (atx_chn_id !== 2'd0 || atx_araddr !== 32'h0 || atx_awaddr !== 32'h0 || atx_arlen !== 8'd0) begin
            failures++;
            $display("FAIL rsthold_fields got chn=%0d ar=%h aw=%h len=%0d exp 0", atx_chn_id, atx_araddr, atx_awaddr, atx_arlen);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        atx_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_vec() !== 4'b0001) begin
            failures++;
            $display("FAIL rsthold_first got rdy=%b exp 0001", rdy_vec());
        end
        advance();
        @(negedge clk);
        checks++;
        if (atx_vld !== 1'b1 || atx_chn_id !== 2'd0 || atx_araddr !== 32'h300) begin
            failures++;
            $display("FAIL rsthold_first_issue got vld=%b chn=%0d ar=%h exp 1 0 300", atx_vld, atx_chn_id, atx_araddr);
        end
        advance();
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_stable();
        test_ostd_limit();
        test_cnt_edges();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adma_atx_scheduler.md
ADMA_ATX_SCHEDULER -- requirements
Module: adma_atx_scheduler

Interface
REQ-001 SHALL have parameters: DMA_CHN_NUM 4, channel count; SRC_ADDR_W 32, source address width; DST_ADDR_W 32, destination address width; MST_ID_W 5, AXI ID width; ATX_LEN_W 8, burst length width; CHN_OSTD_MAX 4, per-channel outstanding limit; DMA_CHN_NUM_W $clog2(DMA_CHN_NUM), derived, not overridden.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chn_req_vld[0:DMA_CHN_NUM-1]  in  1  channel has a transaction.
- chn_req_rdy[0:DMA_CHN_NUM-1]  out  1  channel request accepted.
- chn_araddr[0:DMA_CHN_NUM-1]  in  SRC_ADDR_W  source address.
- chn_awaddr[0:DMA_CHN_NUM-1]  in  DST_ADDR_W  destination address.
- chn_len[0:DMA_CHN_NUM-1]  in  ATX_LEN_W  burst length, AXI encoding.
- chn_burst[0:DMA_CHN_NUM-1]  in  2  burst type.
- atx_id[0:DMA_CHN_NUM-1]  in  MST_ID_W  per-channel AXI ID.
- atx_done[0:DMA_CHN_NUM-1]  in  1  one-cycle completion pulse from the data mover.
- atx_chn_id  out  DMA_CHN_NUM_W  granted channel.
- atx_arid  out  MST_ID_W  read ID.
- atx_araddr  out  SRC_ADDR_W  read address.
- atx_arlen  out  ATX_LEN_W  read length.
- atx_arburst  out  2  read burst type.
- atx_awid  out  MST_ID_W  write ID.
- atx_awaddr  out  DST_ADDR_W  write address.
- atx_awlen  out  ATX_LEN_W  write length.
- atx_awburst  out  2  write burst type.
- atx_vld  out  1  transaction valid to the data mover.
- atx_rdy  in  1  data mover accepts.
- chn_busy[0:DMA_CHN_NUM-1]  out  1  channel has at least one outstanding transaction.

Function
REQ-003 SHALL implement a two-state FSM: IDLE (no transaction held) and HOLD (atx_vld=1).
REQ-004 In IDLE with at least one eligible requester, SHALL grant by round-robin, searching from last_grant+1 upward with wrap at DMA_CHN_NUM-1.
REQ-005 Eligible channel SHALL mean chn_req_vld=1 and, when the limit is compiled in (REQ-018), ostd_cnt<CHN_OSTD_MAX.
REQ-006 In the grant cycle, SHALL assert chn_req_rdy for the granted channel only, combinationally, and for exactly one cycle.
REQ-007 In the grant cycle, SHALL register the granted channel's araddr, awaddr, len, burst and atx_id into the output fields, then enter HOLD in the next cycle.
- arlen=awlen=chn_len; arburst=awburst=chn_burst; arid=awid=atx_id.
REQ-008 Latency SHALL be: request in cycle N with all channels idle, atx_vld=1 in cycle N+1.
REQ-009 In HOLD, outputs SHALL stay stable until atx_rdy=1; changes on channel inputs or atx_id SHALL be ignored.
REQ-010 On HOLD and atx_rdy=1, SHALL:
- return to IDLE, with atx_vld=0 in the next cycle;
- set last_grant to the granted channel;
- increment that channel's ostd_cnt.
Maximum issue rate SHALL be one transaction per two cycles.
REQ-011 chn_req_rdy SHALL be 0 for all channels while in HOLD.
REQ-012 Per channel, ostd_cnt SHALL have width $clog2(CHN_OSTD_MAX+1):
- +1 on issue handshake;
- -1 on atx_done;
- simultaneous issue and done: unchanged;
- done at 0: ignored, no underflow;
- issue at CHN_OSTD_MAX: saturates, no wrap.
REQ-013 chn_busy[i] SHALL equal (ostd_cnt[i]!=0), driven directly from the register.
REQ-014 last_grant SHALL reset to DMA_CHN_NUM-1, so channel 0 has first priority after reset.
REQ-015 With no eligible requester, SHALL stay in IDLE with all chn_req_rdy=0.

Reset
REQ-016 rst_n low SHALL immediately, asynchronously, set:
- FSM to IDLE; atx_vld=0;
- all output fields to 0; all ostd_cnt to 0; chn_busy all 0;
- last_grant to DMA_CHN_NUM-1.
REQ-017 A transaction held in HOLD when reset asserts SHALL be dropped, not replayed after reset.

Configuration
REQ-018 Macro ADMA_SCHED_OSTD_LIMIT_EN:
- defined: channels with ostd_cnt==CHN_OSTD_MAX SHALL be ineligible;
- undefined: eligibility SHALL ignore ostd_cnt; counters and chn_busy SHALL remain, with saturation per REQ-012.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset, then chn_req_vld[2]=1 with araddr=0x1000, awaddr=0x8000, len=15, burst=1, atx_id[2]=5 -> chn_req_rdy[2] pulses once; next cycle atx_vld=1, atx_chn_id=2, arid=awid=5, arlen=awlen=15, araddr=0x1000, awaddr=0x8000.
- All four channels request continuously with atx_rdy=1 -> grant order 0,1,2,3,0; one issue every 2 cycles.
- atx_rdy=0 for 10 cycles in HOLD while channel inputs change -> outputs unchanged; all chn_req_rdy=0; issue on the first cycle atx_rdy=1.
- Macro defined, CHN_OSTD_MAX=4, channel 1 issues 4 times with no done -> channel 1 not granted and other requesters served; one atx_done[1] pulse -> channel 1 granted again.
- atx_done[0] in the same cycle as the channel 0 issue handshake at ostd_cnt=1 -> cnt stays 1; atx_done[3] at cnt=0 -> cnt stays 0, chn_busy[3]=0.
- rst_n low during HOLD -> atx_vld=0 at once, chn_busy all 0; after release the first grant goes to channel 0 when all channels request.
